// File: rtl/missile_launch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : missile_launch_scheduler
// Description : Turns keyboard fire requests into one-hot missile-slot loads.
//               A rising edge of shotKeyIsPress is one request. A request is
//               accepted only in READY with at least one free slot; the
//               lowest-index free slot is loaded one cycle later with a
//               spawn point offset from the ship, and a frame-based cooldown
//               must elapse before the next launch. Rejected requests produce
//               a one-cycle shotDropped pulse and are never queued.
//
// Ports       : clk            - single clock
//               reset          - synchronous active-high reset
//               startOfFrame   - one-cycle pulse per video frame
//               shotKeyIsPress - level fire request
//               spaceShip_X/Y  - ship top-left position (11 bit pixels)
//               slotRetire     - per-slot "missile gone" pulse
//               launch         - one-hot one-cycle slot load pulse
//               launchX/Y      - spawn position, valid while launch != 0
//               slotActive     - per-slot occupancy
//               coolingDown    - cooldown counter nonzero
//               shotDropped    - one-cycle pulse for a rejected request
//
// Revision    : 1.0 - initial release
// ============================================================================
module missile_launch_scheduler #(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 shotKeyIsPress,
    input  logic [10:0]          spaceShip_X,
    input  logic [10:0]          spaceShip_Y,
    input  logic [NUM_SLOTS-1:0] slotRetire,
    output logic [NUM_SLOTS-1:0] launch,
    output logic [10:0]          launchX,
    output logic [10:0]          launchY,
    output logic [NUM_SLOTS-1:0] slotActive,
    output logic                 coolingDown,
    output logic                 shotDropped
);

    // Spawn offset: missile appears centred above the ship's nose.
    localparam logic [10:0]          c_offset_x = 11'd14;
    localparam logic [10:0]          c_offset_y = 11'd8;
    localparam logic [7:0]           c_cooldown = 8'(COOLDOWN_FRAMES);
    localparam logic [NUM_SLOTS-1:0] c_one      = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_FIRE     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_key_prev;
    logic                 w_req;
    logic [NUM_SLOTS-1:0] r_slot_active;
    logic [NUM_SLOTS-1:0] r_launch;
    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_sel;
    logic [NUM_SLOTS-1:0] w_set;
    logic [7:0]           r_cnt;
    logic [10:0]          r_launch_x;
    logic [10:0]          r_launch_y;
    logic                 r_dropped;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_dec;

    // ------------------------------------------------------------------
    // Request detection and slot selection
    // ------------------------------------------------------------------
    // Retires take effect on the next edge, so a slot retiring this cycle
    // is still seen as occupied here.
    always_comb begin
        w_req  = shotKeyIsPress & ~r_key_prev;
        w_free = ~r_slot_active;
        // x & -x isolates the lowest set bit: lowest-index free slot.
        w_sel  = w_free & (~w_free + c_one);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_dec        = 1'b0;

        case (r_state)
            ST_READY: begin
                if (w_req) begin
                    if (|w_free) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_FIRE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end

            ST_FIRE: begin
                w_drop       = w_req;
                w_state_next = ST_COOLDOWN;
            end

            ST_COOLDOWN: begin
                w_drop = w_req;
                if (r_cnt == 8'd0) begin
                    // Defensive exit; the counter is always loaded nonzero.
                    w_state_next = ST_READY;
                end else if (startOfFrame) begin
                    w_dec = 1'b1;
                    // Leave on the same edge the counter hits zero.
                    if (r_cnt == 8'd1) begin
                        w_state_next = ST_READY;
                    end
                end
            end

            default: begin
                w_state_next = ST_READY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Launch, occupancy and cooldown are registered on the accepting edge
    // so they are all visible together during the FIRE cycle. The slot is
    // forced set again during FIRE so a coincident retire cannot clear it.
    always_comb begin
        w_set = r_launch;
        if (w_accept) begin
            w_set = w_set | w_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_prev    <= 1'b0;
            r_slot_active <= '0;
            r_launch      <= '0;
            r_cnt         <= 8'd0;
            r_launch_x    <= 11'd0;
            r_launch_y    <= 11'd0;
            r_dropped     <= 1'b0;
        end else begin
            r_key_prev    <= shotKeyIsPress;
            r_slot_active <= (r_slot_active & ~slotRetire) | w_set;
            r_launch      <= w_accept ? w_sel : '0;
            r_dropped     <= w_drop;

            if (w_accept) begin
                r_cnt <= c_cooldown;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 8'd1;
            end

            // Position is captured only for accepted requests and held
            // until the next launch; arithmetic wraps modulo 2^11.
            if (w_accept) begin
                r_launch_x <= spaceShip_X + c_offset_x;
                r_launch_y <= spaceShip_Y - c_offset_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign launch      = r_launch;
    assign launchX     = r_launch_x;
    assign launchY     = r_launch_y;
    assign slotActive  = r_slot_active;
    assign coolingDown = (r_cnt != 8'd0);
    assign shotDropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_missile_launch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_missile_launch_scheduler
// Description : Directed self-checking bench for missile_launch_scheduler
//               (NUM_SLOTS=4, COOLDOWN_FRAMES=8). Expected values are
//               hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_missile_launch_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        shotKeyIsPress;
    logic [10:0] spaceShip_X;
    logic [10:0] spaceShip_Y;
    logic [3:0]  slotRetire;
    logic [3:0]  launch;
    logic [10:0] launchX;
    logic [10:0] launchY;
    logic [3:0]  slotActive;
    logic        coolingDown;
    logic        shotDropped;

    int n_checks = 0;
    int n_errors = 0;
    int n_launch = 0;
    int n_drop   = 0;

    always #5 clk = ~clk;

    missile_launch_scheduler #(
        .NUM_SLOTS       (4),
        .COOLDOWN_FRAMES (8)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .shotKeyIsPress (shotKeyIsPress),
        .spaceShip_X    (spaceShip_X),
        .spaceShip_Y    (spaceShip_Y),
        .slotRetire     (slotRetire),
        .launch         (launch),
        .launchX        (launchX),
        .launchY        (launchY),
        .slotActive     (slotActive),
        .coolingDown    (coolingDown),
        .shotDropped    (shotDropped)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (launch != 4'd0) n_launch++;
            if (shotDropped)    n_drop++;
        end
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            step(1);
            startOfFrame = 1'b0;
            step(1);
        end
    endtask

    initial begin
        reset          = 1'b1;
        startOfFrame   = 1'b0;
        shotKeyIsPress = 1'b0;
        spaceShip_X    = 11'd100;
        spaceShip_Y    = 11'd400;
        slotRetire     = 4'd0;
        step(2);
        check_val("rst_launch",  launch,      0);
        check_val("rst_x",       launchX,     0);
        check_val("rst_y",       launchY,     0);
        check_val("rst_active",  slotActive,  0);
        check_val("rst_cool",    coolingDown, 0);
        check_val("rst_drop",    shotDropped, 0);

        // First launch from ship (100,400)
        reset = 1'b0;
        step(1);
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("l0_launch", launch,      4'b0001);
        check_val("l0_x",      launchX,     114);
        check_val("l0_y",      launchY,     392);
        check_val("l0_active", slotActive,  4'b0001);
        check_val("l0_cool",   coolingDown, 1);
        check_val("l0_drop",   shotDropped, 0);
        step(1);
        check_val("l0_pulse_end", launch, 0);

        // Held key: no further launches or drops
        n_launch = 0;
        n_drop   = 0;
        frame(100);
        check_val("hold_launches", n_launch, 0);
        check_val("hold_drops",    n_drop,   0);
        check_val("hold_cool",     coolingDown, 0);
        shotKeyIsPress = 1'b0;
        step(1);

        // Slot 1 with wrapping spawn point
        spaceShip_X    = 11'd2040;
        spaceShip_Y    = 11'd3;
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("l1_launch", launch,  4'b0010);
        check_val("l1_x",      launchX, 6);
        check_val("l1_y",      launchY, 2043);
        shotKeyIsPress = 1'b0;
        step(1);
        frame(9);

        // Slot 2
        spaceShip_X    = 11'd0;
        spaceShip_Y    = 11'd0;
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("l2_launch", launch,  4'b0100);
        check_val("l2_x",      launchX, 14);
        check_val("l2_y",      launchY, 2040);
        shotKeyIsPress = 1'b0;
        step(1);

        // Press 3 frames into cooldown is dropped
        frame(3);
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("cd_drop",        shotDropped, 1);
        check_val("cd_drop_launch", launch,      0);
        step(1);
        check_val("cd_drop_pulse",  shotDropped, 0);
        shotKeyIsPress = 1'b0;
        frame(4);
        check_val("cd_after7", coolingDown, 1);
        frame(1);
        check_val("cd_after8", coolingDown, 0);
        check_val("x_hold",    launchX,     14);

        // Slot 3 fills the rack
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("l3_launch", launch,     4'b1000);
        check_val("l3_active", slotActive, 4'b1111);
        shotKeyIsPress = 1'b0;
        step(1);
        frame(8);

        // Fifth press: no free slot
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("full_drop",   shotDropped, 1);
        check_val("full_launch", launch,      0);
        shotKeyIsPress = 1'b0;
        step(1);
        check_val("full_noload", launch,      0);
        check_val("full_cool",   coolingDown, 0);

        // Retire slot 2, then reuse it
        slotRetire = 4'b0100;
        step(1);
        slotRetire = 4'b0000;
        check_val("ret2_active", slotActive, 4'b1011);
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("reuse_launch", launch,     4'b0100);
        check_val("reuse_active", slotActive, 4'b1111);

        // Retire during FIRE: launched slot stays set, other retire honoured
        shotKeyIsPress = 1'b0;
        slotRetire     = 4'b0101;
        step(1);
        slotRetire = 4'b0000;
        check_val("fire_ret_active", slotActive, 4'b1110);
        frame(8);
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("l0b_launch", launch,     4'b0001);
        check_val("l0b_active", slotActive, 4'b1111);
        shotKeyIsPress = 1'b0;
        step(1);
        frame(8);

        // Retire in the request cycle still counts as occupied
        slotRetire     = 4'b0010;
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("sim_ret_drop",   shotDropped, 1);
        check_val("sim_ret_launch", launch,      0);
        check_val("sim_ret_active", slotActive,  4'b1101);
        shotKeyIsPress = 1'b0;
        step(1);
        check_val("ret_inactive", slotActive, 4'b1101);
        slotRetire = 4'b0000;
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("l1b_launch", launch,     4'b0010);
        check_val("l1b_active", slotActive, 4'b1111);
        shotKeyIsPress = 1'b0;
        step(1);
        frame(2);
        slotRetire = 4'b1100;
        step(1);
        slotRetire = 4'b0000;
        check_val("pre_rst_active", slotActive,  4'b0011);
        check_val("pre_rst_cool",   coolingDown, 1);

        // Reset during COOLDOWN, with the key held across release
        reset          = 1'b1;
        shotKeyIsPress = 1'b1;
        step(1);
        check_val("mid_rst_active", slotActive,  0);
        check_val("mid_rst_cool",   coolingDown, 0);
        check_val("mid_rst_launch", launch,      0);
        check_val("mid_rst_x",      launchX,     0);
        check_val("mid_rst_y",      launchY,     0);
        check_val("mid_rst_drop",   shotDropped, 0);
        reset = 1'b0;
        step(1);
        check_val("rel_launch", launch,  4'b0001);
        check_val("rel_x",      launchX, 14);
        shotKeyIsPress = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
